multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multi-cycle RV32I datapath. It is a Moore FSM, with memReady/zero gating on a few enables, that drives every enable and mux select of the datapath per cycle: PC, instruction register, memory, register file, ALU.
- Supports lw, sw, R-type ALU, I-type ALU, lui, beq/bne and jal.
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Parks in a trap state on unsupported encodings.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes current read/write this cycle
- pcWrite  out  1  load PC
- pcSrc  out  2  PC source: 00 ALU result, 01 aluOut register
- adrSrc  out  1  memory address: 0 PC, 1 aluOut
- memRead / memWrite  out  1 each  memory request strobes
- irWrite  out  1  load instruction register (and oldPC)
- regWrite  out  1  register file write enable
- resultSrc  out  2  writeback data: 00 aluOut, 01 memory data, 10 PC
- aluSrcA  out  2  00 PC, 01 rs1, 10 oldPC, 11 zero
- aluSrcB  out  2  00 rs2, 01 constant 4, 10 immediate
- aluOp  out  2  00 add, 01 sub, 10 decode from funct fields
- trap  out  1  illegal instruction; sticky until reset
- oState  out  4  current state (debug)
- oRetired  out  32  retired instruction count (debug)

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, ALUWB=7, BRANCH=8, JAL=9, TRAP=15.
  - Unused codes go to FETCH.
- Output defaults: every output not listed for a state is 0.
- FETCH:
  - Drives memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite=pcWrite=memReady.
  - Advances to DECODE only when memReady=1; otherwise it holds.
- DECODE:
  - Drives aluSrcA=10, aluSrcB=10, aluOp=00, so aluOut = branch/jal target.
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011, 0010011 or 0110111 -> EXEC
    - 1100011 with funct3 000/001 -> BRANCH
    - 1101111 -> JAL
    - anything else, including branch funct3 other than 000/001 -> TRAP
- MEMADR:
  - Drives aluSrcA=01, aluSrcB=10, aluOp=00.
  - Goes to MEMREAD if opcode is lw, else MEMWRITE.
- MEMREAD:
  - Drives memRead=1, adrSrc=1.
  - Holds until memReady, then goes to MEMWB.
- MEMWB: regWrite=1, resultSrc=01; goes to FETCH.
- MEMWRITE:
  - Drives memWrite=1, adrSrc=1.
  - Holds until memReady, then goes to FETCH.
- EXEC:
  - R-type: aluSrcA=01, aluSrcB=00, aluOp=10.
  - I-type: aluSrcA=01, aluSrcB=10, aluOp=10.
  - lui: aluSrcA=11, aluSrcB=10, aluOp=00.
  - Goes to ALUWB.
- ALUWB: regWrite=1, resultSrc=00; goes to FETCH.
- BRANCH:
  - Drives aluSrcA=01, aluSrcB=00, aluOp=01, pcSrc=01.
  - pcWrite = zero XOR funct3[0], so beq is taken on zero and bne on !zero.
  - Goes to FETCH.
- JAL:
  - Drives pcWrite=1, pcSrc=01, regWrite=1, resultSrc=10.
  - The PC register already holds the link address (pc+4).
  - Goes to FETCH.
- TRAP: trap=1, all enables 0; stays in TRAP until reset.
- oRetired:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or JAL.
  - Wraps from 0xFFFFFFFF to 0.
  - A trapped instruction is not counted.

## Timing
- Reset state:
  - State=FETCH, oRetired=0, trap=0.
  - Outputs take their FETCH values with memReady gating; all other enables are 0.
- Reset is asynchronous. Asserting it mid-instruction (including during a memory wait) forces FETCH immediately, and no write enable stays asserted after the reset edge.
- State register updates on the rising clock edge; outputs are combinational from state, opcode, funct3, zero and memReady.
- Cycle counts with memReady held at 1:
  - lw 5; sw 4; R-type, I-type and lui 4; beq/bne 3; jal 3.
  - Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- memReady is ignored outside FETCH, MEMREAD and MEMWRITE.
- zero is sampled only in BRANCH.

## Test plan
- Reset, then memReady=1 with opcode=0110011 -> oState sequence 0,1,6,7,0:
  - regWrite=1 only in state 7.
  - oRetired=1 after the sequence.
- lw (0000011) with memReady=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; memRead=1 and adrSrc=1 throughout state 3.
- beq (1100011, funct3=000):
  - zero=1 -> pcWrite=1 with pcSrc=01 in BRANCH.
  - Repeat with zero=0 -> pcWrite=0.
  - bne (funct3=001) with zero=0 -> pcWrite=1.
- jal (1101111) -> state 9 asserts pcWrite=1, pcSrc=01, regWrite=1 and resultSrc=10 in the same cycle.
- opcode=1110011 or branch funct3=100 -> TRAP (oState=15):
  - trap=1 and all enables 0 for 10 cycles.
  - oRetired unchanged.
  - Reset returns to FETCH with trap=0.
- Retired counter wrap and reset mid-instruction:
  - Force oRetired to 0xFFFFFFFF and retire one instruction -> oRetired=0.
  - Assert reset asynchronously during MEMWRITE -> memWrite drops before the next clock edge and oState=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing FSM for the multi-cycle RV32I datapath
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        memReady,
  output logic        pcWrite,
  output logic [1:0]  pcSrc,
  output logic        adrSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        trap,
  output logic [3:0]  oState,
  output logic [31:0] oRetired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JAL = 4'd9,
    TRAP = 4'd15
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  state_t state, next;
  logic retire;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = memReady ? DECODE : FETCH;
      DECODE:   next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                       (opcode == OP_R || opcode == OP_I || opcode == OP_LUI) ? EXEC :
                       (opcode == OP_BR && funct3[2:1] == 2'b00) ? BRANCH :
                       (opcode == OP_JAL) ? JAL : TRAP;
      MEMADR:   next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next = memReady ? MEMWB : MEMREAD;
      MEMWRITE: next = memReady ? FETCH : MEMWRITE;
      EXEC:     next = ALUWB;
      TRAP:     next = TRAP;
      default:  next = FETCH;
    endcase
  end
  always_comb begin
    pcWrite   = 1'b0;
    pcSrc     = 2'b00;
    adrSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    trap      = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b10;
      end
      MEMADR: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
      end
      MEMREAD: begin
        memRead = 1'b1;
        adrSrc  = 1'b1;
      end
      MEMWB: begin
        regWrite  = 1'b1;
        resultSrc = 2'b01;
      end
      MEMWRITE: begin
        memWrite = 1'b1;
        adrSrc   = 1'b1;
      end
      EXEC: begin
        aluSrcA = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        aluSrcB = (opcode == OP_R) ? 2'b00 : 2'b10;
        aluOp   = (opcode == OP_LUI) ? 2'b00 : 2'b10;
      end
      ALUWB: regWrite = 1'b1;
      BRANCH: begin
        aluSrcA = 2'b01;
        aluOp   = 2'b01;
        pcSrc   = 2'b01;
        pcWrite = zero ^ funct3[0];
      end
      JAL: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b01;
        regWrite  = 1'b1;
        resultSrc = 2'b10;
      end
      TRAP: trap = 1'b1;
      default: ;
    endcase
  end
  // an instruction retires when its last state hands control back to FETCH
  assign retire = (next == FETCH) && (state inside {MEMWB, MEMWRITE, ALUWB, BRANCH, JAL});
  assign oState = state;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      oRetired <= '0;
    end else begin
      state <= next;
      if (retire) oRetired <= oRetired + 32'd1;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors with hand-computed expectations
module tb_multicycle_control;
  logic        clock, reset, zero, memReady;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        pcWrite, adrSrc, memRead, memWrite, irWrite, regWrite, trap;
  logic [1:0]  pcSrc, resultSrc, aluSrcA, aluSrcB, aluOp;
  logic [3:0]  oState;
  logic [31:0] oRetired;
  int n_chk = 0;
  int n_bad = 0;
  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .memReady(memReady), .pcWrite(pcWrite), .pcSrc(pcSrc), .adrSrc(adrSrc),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .trap(trap), .oState(oState), .oRetired(oRetired)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask
  initial begin
    reset = 1'b1; memReady = 1'b0; zero = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    #1;
    check("rst_state", oState, 0);
    check("rst_retired", oRetired, 0);
    check("rst_trap", trap, 0);
    check("rst_memread", memRead, 1);
    check("rst_en", {pcWrite, irWrite, memWrite, regWrite}, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    opcode = 7'b0110011; memReady = 1'b1;
    #1;
    check("r_fetch", oState, 0);
    check("r_irwrite", {irWrite, pcWrite}, 2'b11);
    cyc(); check("r_dec", oState, 1); check("r_dec_rw", regWrite, 0);
    check("r_dec_alu", {aluSrcA, aluSrcB, aluOp}, 6'b10_10_00);
    cyc(); check("r_exec", oState, 6); check("r_exec_rw", regWrite, 0);
    check("r_exec_alu", {aluSrcA, aluSrcB, aluOp}, 6'b01_00_10);
    cyc(); check("r_wb", oState, 7); check("r_wb_rw", regWrite, 1);
    check("r_wb_res", resultSrc, 0);
    cyc(); check("r_end", oState, 0); check("r_ret", oRetired, 1);
    opcode = 7'b0000011;
    cyc(3); memReady = 1'b0; #1;
    check("lw_mr0", oState, 3); check("lw_mr0_rd", {memRead, adrSrc}, 2'b11);
    cyc(); check("lw_mr1", oState, 3); check("lw_mr1_rd", {memRead, adrSrc}, 2'b11);
    cyc(); memReady = 1'b1; #1;
    check("lw_mr2", oState, 3); check("lw_mr2_rd", {memRead, adrSrc}, 2'b11);
    cyc(); check("lw_wb", oState, 4); check("lw_wb_en", {regWrite, resultSrc}, 3'b1_01);
    cyc(); check("lw_end", oState, 0); check("lw_ret", oRetired, 2);
    opcode = 7'b1100011; funct3 = 3'b000;
    cyc(2); zero = 1'b1; #1;
    check("beq_t_state", oState, 8);
    check("beq_t_pc", {pcWrite, pcSrc, aluOp}, 5'b1_01_01);
    cyc(); check("beq_t_ret", oRetired, 3);
    cyc(2); zero = 1'b0; #1;
    check("beq_n_pc", pcWrite, 0);
    cyc(); funct3 = 3'b001;
    cyc(2); #1;
    check("bne_t_state", oState, 8);
    check("bne_t_pc", {pcWrite, pcSrc}, 3'b1_01);
    cyc(); check("bne_ret", oRetired, 5);
    opcode = 7'b1101111; funct3 = 3'b000;
    cyc(2);
    check("jal_state", oState, 9);
    check("jal_en", {pcWrite, pcSrc, regWrite, resultSrc}, 6'b1_01_1_10);
    cyc(); check("jal_ret", oRetired, 6);
    opcode = 7'b0100011; memReady = 1'b0; #1;
    check("f_stall_ir", irWrite, 0);
    cyc(); check("f_stall", oState, 0);
    memReady = 1'b1;
    cyc(3); memReady = 1'b0; #1;
    check("sw_wait", oState, 5); check("sw_wait_en", {memWrite, adrSrc, memRead}, 3'b110);
    cyc(); check("sw_hold", oState, 5);
    memReady = 1'b1;
    cyc(); check("sw_ret", oRetired, 7);
    opcode = 7'b1110011;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      check("trap_state", oState, 15);
      check("trap_flag", trap, 1);
      check("trap_en", {pcWrite, irWrite, memRead, memWrite, regWrite}, 0);
      cyc();
    end
    check("trap_ret", oRetired, 7);
    memReady = 1'b0; reset = 1'b1; #1;
    check("trap_rst_state", oState, 0);
    check("trap_rst_flag", trap, 0);
    reset = 1'b0;
    opcode = 7'b1100011; funct3 = 3'b100; memReady = 1'b1;
    cyc(2);
    check("br100_trap", oState, 15);
    check("br100_flag", trap, 1);
    memReady = 1'b0; reset = 1'b1; #1; reset = 1'b0;
    cyc();
    force dut.oRetired = 32'hFFFF_FFFF;
    #1 release dut.oRetired;
    #1 check("wrap_pre", oRetired, 32'hFFFF_FFFF);
    opcode = 7'b1101111; funct3 = 3'b000; memReady = 1'b1;
    cyc(3); check("wrap_post", oRetired, 0);
    check("wrap_state", oState, 0);
    opcode = 7'b0100011;
    cyc(3); memReady = 1'b0; #1;
    check("mid_memwrite", memWrite, 1);
    reset = 1'b1; #1;
    check("mid_rst_mw", memWrite, 0);
    check("mid_rst_state", oState, 0);
    reset = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
